// File: rtl/sim_quit_sequencer.sv
// End-of-simulation sequencer: counts clock edges, watches the cosim
// watchdog and the TestBench idle flag, and walks RUN -> DRAIN -> DONE/FAIL.
// Also produces the registered wave-dump window enable.
module sim_quit_sequencer #(
    parameter int          CYCLE_WIDTH  = 64,
    parameter int          STATUS_WIDTH = 8,
    parameter int unsigned QUIT_CODE    = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    watchdogValid,
    input  logic [STATUS_WIDTH-1:0] watchdogStatus,
    input  logic                    idle,
    input  logic [CYCLE_WIDTH-1:0]  timeoutAfterQuit,
    input  logic [CYCLE_WIDTH-1:0]  globalTimeout,
    input  logic [CYCLE_WIDTH-1:0]  dumpStart,
    input  logic [CYCLE_WIDTH-1:0]  dumpEnd,
    output logic [CYCLE_WIDTH-1:0]  cycle,
    output logic [CYCLE_WIDTH-1:0]  quitCycle,
    output logic                    dumpEnable,
    output logic                    finish,
    output logic                    fatal,
    output logic [1:0]              fatalCode,
    output logic [1:0]              state
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAIL  = 2'd3
    } state_e;

    localparam logic [STATUS_WIDTH-1:0] QUIT     = STATUS_WIDTH'(QUIT_CODE);
    localparam logic [CYCLE_WIDTH-1:0]  ONE      = CYCLE_WIDTH'(1);
    localparam logic [CYCLE_WIDTH-1:0]  ZERO     = '0;
    localparam logic [1:0]              CODE_WD  = 2'd1;
    localparam logic [1:0]              CODE_IDL = 2'd2;
    localparam logic [1:0]              CODE_GLB = 2'd3;

    state_e                 state_q, state_d;
    logic [CYCLE_WIDTH-1:0] cycle_q, cycle_d;
    logic [CYCLE_WIDTH-1:0] quit_cycle_q, quit_cycle_d;
    logic                   dump_q, dump_d;
    logic                   finish_q, finish_d;
    logic                   fatal_q, fatal_d;
    logic [1:0]             code_q, code_d;

    logic [CYCLE_WIDTH-1:0] edge_num;
    logic [CYCLE_WIDTH:0]   drain_limit;
    logic                   active;
    logic                   quit_hit;
    logic                   done_hit;
    logic                   wd_err;
    logic                   idle_to;
    logic                   glb_to;
    logic                   in_window;

    // Edge decode and next-state/output computation for the sequencer
    always_comb begin
        state_d      = state_q;
        cycle_d      = cycle_q;
        quit_cycle_d = quit_cycle_q;
        dump_d       = dump_q;
        finish_d     = 1'b0;
        fatal_d      = fatal_q;
        code_d       = code_q;

        // Edge number saturates so the counter never wraps back to zero
        edge_num    = (&cycle_q) ? cycle_q : cycle_q + ONE;
        // One extra bit so quitCycle + timeout can never overflow
        drain_limit = {1'b0, quit_cycle_q} + {1'b0, timeoutAfterQuit};

        active   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        quit_hit = (state_q == ST_RUN) && watchdogValid && (watchdogStatus == QUIT);
        // The watchdog is only consulted in RUN; after quit it is ignored
        wd_err   = (state_q == ST_RUN) && watchdogValid &&
                   (watchdogStatus != '0) && (watchdogStatus != QUIT);
        done_hit = (quit_hit && idle) || ((state_q == ST_DRAIN) && idle);
        idle_to  = (state_q == ST_DRAIN) && !idle && ({1'b0, edge_num} > drain_limit);
        glb_to   = (globalTimeout != ZERO) && (edge_num == globalTimeout);

        in_window = (edge_num >= dumpStart) && ((dumpEnd == ZERO) || (edge_num < dumpEnd));

        if (active) begin
            cycle_d = edge_num;
            dump_d  = in_window;
            if (quit_hit) begin
                quit_cycle_d = edge_num;
            end
            if (done_hit) begin
                state_d  = ST_DONE;
                finish_d = 1'b1;
                dump_d   = 1'b0;
            end else if (wd_err) begin
                state_d = ST_FAIL;
                fatal_d = 1'b1;
                code_d  = CODE_WD;
                dump_d  = 1'b0;
            end else if (idle_to) begin
                state_d = ST_FAIL;
                fatal_d = 1'b1;
                code_d  = CODE_IDL;
                dump_d  = 1'b0;
            end else if (glb_to) begin
                state_d = ST_FAIL;
                fatal_d = 1'b1;
                code_d  = CODE_GLB;
                dump_d  = 1'b0;
            end else if (quit_hit) begin
                state_d = ST_DRAIN;
            end
        end
    end

    // State and registered outputs; async active-low reset clears everything
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            cycle_q      <= '0;
            quit_cycle_q <= '0;
            dump_q       <= 1'b0;
            finish_q     <= 1'b0;
            fatal_q      <= 1'b0;
            code_q       <= 2'd0;
        end else begin
            state_q      <= state_d;
            cycle_q      <= cycle_d;
            quit_cycle_q <= quit_cycle_d;
            dump_q       <= dump_d;
            finish_q     <= finish_d;
            fatal_q      <= fatal_d;
            code_q       <= code_d;
        end
    end

    assign cycle      = cycle_q;
    assign quitCycle  = quit_cycle_q;
    assign dumpEnable = dump_q;
    assign finish     = finish_q;
    assign fatal      = fatal_q;
    assign fatalCode  = code_q;
    assign state      = state_q;

endmodule

// File: tb/tb_sim_quit_sequencer.sv
// Bench for sim_quit_sequencer: an edge-level reference model checked every
// cycle, plus literal expectations from the directed scenarios.
module tb_sim_quit_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        watchdogValid = 1'b0;
    logic [7:0]  watchdogStatus = '0;
    logic        idle = 1'b0;
    logic [63:0] timeoutAfterQuit = 64'd1000;
    logic [63:0] globalTimeout = '0;
    logic [63:0] dumpStart = '0;
    logic [63:0] dumpEnd = '0;
    logic [63:0] cycle, quitCycle;
    logic        dumpEnable, finish, fatal;
    logic [1:0]  fatalCode, state;

    int n_vec = 0;
    int n_bad = 0;

    sim_quit_sequencer dut (
        .clock(clock), .reset(reset),
        .watchdogValid(watchdogValid), .watchdogStatus(watchdogStatus), .idle(idle),
        .timeoutAfterQuit(timeoutAfterQuit), .globalTimeout(globalTimeout),
        .dumpStart(dumpStart), .dumpEnd(dumpEnd),
        .cycle(cycle), .quitCycle(quitCycle), .dumpEnable(dumpEnable),
        .finish(finish), .fatal(fatal), .fatalCode(fatalCode), .state(state)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0]  st;
        logic [63:0] cyc;
        logic [63:0] qc;
        logic        fin;
        logic        fat;
        logic [1:0]  code;
        logic        dump;
    } mdl_t;

    mdl_t m;

    // Reference: apply the sequencing rules for one edge
    function automatic mdl_t model_edge(input mdl_t c);
        mdl_t n;
        logic [63:0] e;
        logic [64:0] lim;
        bit running, quit, done, err, ito, gto;
        n = c;
        n.fin = 1'b0;
        running = (c.st == 2'd0) || (c.st == 2'd1);
        if (!running) return n;
        e    = (c.cyc == 64'hFFFF_FFFF_FFFF_FFFF) ? c.cyc : c.cyc + 64'd1;
        lim  = 65'(c.qc) + 65'(timeoutAfterQuit);
        quit = (c.st == 2'd0) && watchdogValid && (watchdogStatus == 8'd255);
        done = (quit && idle) || (c.st == 2'd1 && idle);
        err  = (c.st == 2'd0) && watchdogValid && watchdogStatus != 8'd0 && watchdogStatus != 8'd255;
        ito  = (c.st == 2'd1) && !idle && (65'(e) > lim);
        gto  = (globalTimeout != 0) && (e == globalTimeout);
        n.cyc  = e;
        n.dump = (e >= dumpStart) && (dumpEnd == 0 || e < dumpEnd);
        if (quit) n.qc = e;
        if (done)      begin n.st = 2'd2; n.fin = 1'b1; end
        else if (err)  begin n.st = 2'd3; n.fat = 1'b1; n.code = 2'd1; end
        else if (ito)  begin n.st = 2'd3; n.fat = 1'b1; n.code = 2'd2; end
        else if (gto)  begin n.st = 2'd3; n.fat = 1'b1; n.code = 2'd3; end
        else if (quit) n.st = 2'd1;
        if (n.st == 2'd2 || n.st == 2'd3) n.dump = 1'b0;
        return n;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) m <= '0;
        else        m <= model_edge(m);
    end

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clock) begin
        n_vec++;
        if ({state, cycle, quitCycle, finish, fatal, fatalCode, dumpEnable} !== m) begin
            n_bad++;
            $display("FAIL model t=%0t state %0d want %0d cycle %0d want %0d quit %0d want %0d fin %0b want %0b fat %0b want %0b code %0d want %0d dump %0b want %0b",
                     $time, state, m.st, cycle, m.cyc, quitCycle, m.qc, finish, m.fin,
                     fatal, m.fat, fatalCode, m.code, dumpEnable, m.dump);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] s, input logic i);
        watchdogValid = v;
        watchdogStatus = s;
        idle = i;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        watchdogValid = 1'b0;
        watchdogStatus = '0;
        idle = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        @(negedge clock);
        // Reset state
        do_reset();
        chk("rst_state", 64'(state), 0);
        chk("rst_cycle", cycle, 0);

        // Quit with idle at edge 10
        do_reset();
        repeat (9) step(1, 8'd0, 0);
        step(1, 8'd255, 1);
        chk("q_state", 64'(state), 2);
        chk("q_finish", 64'(finish), 1);
        chk("q_cycle", cycle, 10);
        chk("q_quitcyc", quitCycle, 10);
        chk("q_fatal", 64'(fatal), 0);
        step(0, 8'd0, 0);
        chk("q_finish_drop", 64'(finish), 0);
        chk("q_cycle_frozen", cycle, 10);

        // Drain success
        timeoutAfterQuit = 64'd4;
        do_reset();
        repeat (9) step(1, 8'd0, 0);
        step(1, 8'd255, 0);
        chk("d_state_drain", 64'(state), 1);
        repeat (3) step(0, 8'd0, 0);
        step(0, 8'd0, 1);
        chk("d_state_done", 64'(state), 2);
        chk("d_cycle", cycle, 14);
        chk("d_fatal", 64'(fatal), 0);

        // Drain timeout; watchdog errors during drain are ignored
        do_reset();
        repeat (9) step(1, 8'd0, 0);
        step(1, 8'd255, 0);
        repeat (4) step(1, 8'd7, 0);
        chk("t_still_drain", 64'(state), 1);
        step(0, 8'd0, 0);
        chk("t_state", 64'(state), 3);
        chk("t_code", 64'(fatalCode), 2);
        chk("t_cycle", cycle, 15);
        timeoutAfterQuit = 64'd1000;

        // Watchdog error at edge 3, then terminal
        do_reset();
        repeat (2) step(1, 8'd0, 0);
        step(1, 8'd7, 0);
        chk("w_state", 64'(state), 3);
        chk("w_code", 64'(fatalCode), 1);
        chk("w_cycle", cycle, 3);
        repeat (3) step(1, 8'd255, 1);
        chk("w_finish", 64'(finish), 0);
        chk("w_state_held", 64'(state), 3);
        chk("w_cycle_held", cycle, 3);

        // Global timeout and priority
        globalTimeout = 64'd5;
        do_reset();
        repeat (5) step(1, 8'd0, 0);
        chk("g_state", 64'(state), 3);
        chk("g_code", 64'(fatalCode), 3);
        do_reset();
        repeat (4) step(1, 8'd0, 0);
        step(1, 8'd255, 1);
        chk("g_done_wins", 64'(state), 2);
        do_reset();
        repeat (4) step(1, 8'd0, 0);
        step(1, 8'd9, 0);
        chk("g_wd_wins", 64'(fatalCode), 1);
        globalTimeout = '0;

        // Dump window and async reset in drain
        dumpStart = 64'd3;
        dumpEnd = 64'd6;
        do_reset();
        step(0, 8'd0, 0);
        chk("dump_e1", 64'(dumpEnable), 0);
        step(0, 8'd0, 0);
        chk("dump_e2", 64'(dumpEnable), 0);
        step(0, 8'd0, 0);
        chk("dump_e3", 64'(dumpEnable), 1);
        repeat (2) step(0, 8'd0, 0);
        chk("dump_e5", 64'(dumpEnable), 1);
        step(0, 8'd0, 0);
        chk("dump_e6", 64'(dumpEnable), 0);
        step(1, 8'd255, 0);
        step(0, 8'd0, 0);
        chk("r_in_drain", 64'(state), 1);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("r_async_state", 64'(state), 0);
        chk("r_async_cycle", cycle, 0);
        chk("r_async_quit", quitCycle, 0);
        chk("r_async_misc", {59'd0, dumpEnable, finish, fatal, fatalCode}, 0);
        @(negedge clock);
        reset = 1'b1;
        step(0, 8'd0, 0);
        chk("r_restart_cycle", cycle, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sim_quit_sequencer.md
Name: sim_quit_sequencer

Overview:
Synthesizable end-of-simulation controller for the t1rocketemu testbench top. It owns the cycle count, samples the per-cycle cosim watchdog status and the TestBench idle signal, and sequences RUN -> DRAIN -> DONE/FAIL. It also gates the wave-dump window. It replaces behavioural cycle-hook logic, so the top-level testbench only turns `finish`/`fatal` into `$finish`/`$fatal`.

Parameters:
CYCLE_WIDTH, 64, width of all cycle counters and cycle config inputs
STATUS_WIDTH, 8, width of watchdog status
QUIT_CODE, 255, watchdog status value meaning "cosim quit"

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
watchdogValid  input  1  watchdogStatus is valid this cycle
watchdogStatus  input  STATUS_WIDTH  0 = continue, QUIT_CODE = quit, any other value = error
idle  input  1  TestBench idle
timeoutAfterQuit  input  CYCLE_WIDTH  max drain cycles after quit; quasi-static
globalTimeout  input  CYCLE_WIDTH  global cycle limit; 0 = disabled; quasi-static
dumpStart  input  CYCLE_WIDTH  first edge number with dump enabled; quasi-static
dumpEnd  input  CYCLE_WIDTH  first edge number with dump disabled; 0 = never; quasi-static
cycle  output  CYCLE_WIDTH  number of rising edges since reset release
quitCycle  output  CYCLE_WIDTH  edge number at which quit was sampled; 0 if none
dumpEnable  output  1  wave dump window active
finish  output  1  one-cycle pulse on entry to DONE
fatal  output  1  level, high while in FAIL
fatalCode  output  2  0 none, 1 watchdog error, 2 idle timeout after quit, 3 global timeout
state  output  2  0 RUN, 1 DRAIN, 2 DONE, 3 FAIL

Behaviour:
- Reset (reset==0, async): state=RUN, cycle=0, quitCycle=0, dumpEnable=0, finish=0, fatal=0, fatalCode=0, drain counter=0.
- Edge number: E = cycle+1 at each rising edge in RUN/DRAIN.
  - All decisions at an edge use E and the inputs sampled at that edge.
  - cycle<=E, saturating at all-ones.
  - cycle freezes in DONE/FAIL.
- RUN:
  - watchdogValid=0 or status==0: stay in RUN.
  - status==QUIT_CODE: quitCycle<=E. If idle=1 at the same edge -> DONE; else -> DRAIN with drain counter=0.
  - Any other status with watchdogValid=1 -> FAIL, fatalCode=1.
- DRAIN:
  - watchdogValid/status are ignored; the watchdog is not consulted after quit.
  - idle=1 -> DONE.
  - Else if E > quitCycle + timeoutAfterQuit -> FAIL, fatalCode=2. The addition saturates and is computed at CYCLE_WIDTH+1 bits.
- Global timeout: globalTimeout!=0 and E==globalTimeout -> FAIL, fatalCode=3.
- Priority at a single edge: DONE condition > watchdog error (code 1) > idle timeout (code 2) > global timeout (code 3).
- DONE and FAIL are terminal until reset. finish=1 for exactly the first cycle after entering DONE, then 0. fatal and fatalCode are held.
- dumpEnable is registered. In RUN/DRAIN: dumpEnable <= (E >= dumpStart) && (dumpEnd==0 || E < dumpEnd). It is forced to 0 on the edge that enters DONE/FAIL.
  - dumpStart=0 enables the dump from edge 1.
  - dumpEnd <= dumpStart gives an empty window.
- Reset asserted mid-DRAIN or in a terminal state returns all outputs to their reset values immediately, without waiting for a clock edge.
- Config inputs are sampled every edge. Changing them during RUN is legal but not verified.

Test Plan:
- Quit with idle: status 0 for edges 1-9, status 255 with idle=1 at edge 10 -> state DONE, finish pulse one cycle, cycle=10, quitCycle=10, fatal=0.
- Drain success: quit at edge 10 with idle=0, timeoutAfterQuit=4, idle=1 at edge 14 -> DONE at edge 14, no FAIL.
- Drain timeout: quit at edge 10, timeoutAfterQuit=4, idle held 0 -> FAIL at edge 15, fatalCode=2, cycle=15.
- Watchdog error: status 7 at edge 3 -> FAIL, fatalCode=1, cycle=3. Later status 255 and idle=1 -> no change, finish never pulses.
- Global timeout and priority:
  - globalTimeout=5, status always 0 -> FAIL at edge 5, fatalCode=3.
  - Status 255 with idle=1 at edge 5 -> DONE instead.
  - Status 9 at edge 5 -> fatalCode=1.
- Dump window and reset: dumpStart=3, dumpEnd=6 -> dumpEnable high after edges 3,4,5 and low after edge 6. Asserting reset in DRAIN -> all outputs 0 asynchronously; after release, cycle restarts at 1.
